// File: rtl/prng_arb_pkg.sv
// Shared types and defaults for the PRNG round-robin arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package prng_arb_pkg;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } arb_state_e;

  localparam int NUM_REQ_DEF    = 4;
  localparam int RAND_W_DEF     = 12;
  localparam int WARMUP_CYC_DEF = 16;

  // Next index after idx in a ring of n entries. An explicit compare keeps
  // non-power-of-two ring sizes correct.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of eligible, scanning upward from rr_ptr with wrap.
// Latency: purely combinational.
// Backpressure: none; valid=0 when no bit of eligible is set.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               valid
);

  // rr_ptr + off, folded back into 0..NUM_REQ-1 by compare rather than overflow.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum > NUM_REQ - 1) sum = sum - NUM_REQ;
    return PTR_W'(sum);
  endfunction

  logic [PTR_W-1:0] cand;

  // Scan from the farthest offset back toward rr_ptr so the nearest eligible index wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = wrap_add(rr_ptr, k);
      if (eligible[cand]) begin
        winner = cand;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prng_rr_arbiter.sv
// Shares one PRNG stream among NUM_REQ consumers: one round-robin grant per cycle after warm-up.
// Latency: req seen before edge k -> registered one-cycle gnt + rand_out after edge k.
// Backpressure: none; en=0 or no eligible req gives gnt=0 and holds rand_out/rr_ptr.
// Optional PRNG_ARB_STATS_EN adds grant_cnt and starve_flag outputs.
module prng_rr_arbiter
  import prng_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int RAND_W     = RAND_W_DEF,
  parameter int WARMUP_CYC = WARMUP_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [RAND_W-1:0]  rand_num,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [RAND_W-1:0]  rand_out,
  output logic               ready
`ifdef PRNG_ARB_STATS_EN
  ,
  output logic [31:0]        grant_cnt,
  output logic [NUM_REQ-1:0] starve_flag
`endif
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int WCNT_W = $clog2(WARMUP_CYC + 1);

  arb_state_e        state, state_nxt;
  logic [WCNT_W-1:0] warm_cnt;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_vld;
  logic              arb_ok;
  logic [NUM_REQ-1:0] eligible;

  // A requester granted this cycle sits out the next one, so held req is never double-granted.
  assign eligible = req & ~gnt;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .winner   (pick_idx),
    .valid    (pick_vld)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WARMUP;
    else        state <= state_nxt;
  end

  // Leave WARMUP on the WARMUP_CYC-th edge after reset release; RUN is terminal.
  always_comb begin
    state_nxt = state;
    if (state == WARMUP && warm_cnt == WCNT_W'(WARMUP_CYC - 1)) state_nxt = RUN;
  end

  // Outputs decoded from state.
  always_comb begin
    ready  = (state == RUN);
    arb_ok = (state == RUN) && en;
  end

  // Warm-up counter: counts discarded PRNG cycles, frozen once running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                warm_cnt <= '0;
    else if (state == WARMUP)  warm_cnt <= warm_cnt + 1'b1;
  end

  // Grant register: one-hot pulse, sample capture and pointer advance past the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      rand_out <= '0;
      rr_ptr   <= '0;
    end else if (arb_ok && pick_vld) begin
      gnt      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
      rand_out <= rand_num;
      rr_ptr   <= PTR_W'(wrap_inc(int'(pick_idx), NUM_REQ));
    end else begin
      gnt      <= '0;
    end
  end

`ifdef PRNG_ARB_STATS_EN
  localparam int SW = $clog2(2 * NUM_REQ + 2);

  logic [SW-1:0] wait_cnt [NUM_REQ];

  // Saturating count of issued grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          grant_cnt <= '0;
    else if (|gnt && grant_cnt != '1)    grant_cnt <= grant_cnt + 32'd1;
  end

  // Per-requester wait counters; flag sticks once a req waits more than 2*NUM_REQ RUN cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_flag <= '0;
      for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ready && req[i] && !gnt[i]) begin
          if (wait_cnt[i] != SW'(2 * NUM_REQ + 1)) wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end else begin
          wait_cnt[i] <= '0;
        end
        if (wait_cnt[i] > SW'(2 * NUM_REQ)) starve_flag[i] <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_prng_rr_arbiter.sv
// Self-checking bench for prng_rr_arbiter (default build, 4 requesters, 12-bit samples).
module tb_prng_rr_arbiter;

  localparam int N  = 4;
  localparam int RW = 12;
  localparam int WU = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] rand_num;
  logic          en;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [RW-1:0] rand_out;
  logic          ready;

  int errors = 0;
  int checks = 0;

  prng_rr_arbiter #(.NUM_REQ(N), .RAND_W(RW), .WARMUP_CYC(WU)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rand_num (rand_num),
    .en       (en),
    .req      (req),
    .gnt      (gnt),
    .rand_out (rand_out),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sample source: full-period odd stride, changed 2 time units after each edge.
  always @(posedge clk) begin
    #2;
    rand_num = rand_num + 12'd1597;
  end

  // Reference model: edges since reset release, ring pointer as an integer,
  // winner found by a plain modular scan over req minus last grant.
  int            m_edges = 0;
  int            m_ptr   = 0;
  logic [N-1:0]  m_gnt   = '0;
  logic [RW-1:0] m_rand  = '0;
  logic          m_ready = 1'b0;
  logic [RW-1:0] m_edge_rand = '0;

  always @(posedge clk or negedge rst_n) begin
    int  win;
    bit  found;
    if (!rst_n) begin
      m_edges = 0; m_ptr = 0; m_gnt = '0; m_rand = '0; m_ready = 1'b0;
    end else begin
      m_edge_rand = rand_num;
      found = 1'b0;
      win   = 0;
      if (m_edges >= WU && en) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (!found && req[j] && !m_gnt[j]) begin
            found = 1'b1;
            win   = j;
          end
        end
      end
      if (found) begin
        m_gnt  = N'(1 << win);
        m_rand = rand_num;
        m_ptr  = (win + 1) % N;
      end else begin
        m_gnt  = '0;
      end
      m_edges++;
      m_ready = (m_edges >= WU);
    end
  end

  // Every-cycle comparison against the model plus grant-shape properties.
  logic [N-1:0] prev_gnt = '0;
  always @(negedge clk) begin
    chk("model_gnt",      32'(gnt),      32'(m_gnt));
    chk("model_ready",    32'(ready),    32'(m_ready));
    chk("model_rand_out", 32'(rand_out), 32'(m_rand));
    chk("onehot0",        32'($onehot0(gnt)), 32'd1);
    chk("no_back_to_back", 32'(|(gnt & prev_gnt)), 32'd0);
    prev_gnt = gnt;
  end

  logic [N-1:0]  seq [5];
  logic [RW-1:0] held;
  int            cnt [N];
  longint        sum;
  int            total, maxc, minc;

  initial begin
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_n    = 1'b0;
    rand_num = 12'h5A3;
    req      = 4'b1111;
    en       = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_gnt",      32'(gnt),      32'd0);
    chk("rst_ready",    32'(ready),    32'd0);
    chk("rst_rand_out", 32'(rand_out), 32'd0);

    // Warm-up: no grant for 16 edges, ready rises on the 16th.
    rst_n = 1'b1;
    for (int e = 1; e <= WU; e++) begin
      @(negedge clk);
      chk("warm_gnt",   32'(gnt),   32'd0);
      chk("warm_ready", 32'(ready), (e == WU) ? 32'd1 : 32'd0);
    end
    for (int e = 0; e < 5; e++) begin
      @(negedge clk);
      chk("rr_seq", 32'(gnt), 32'(seq[e]));
    end

    // Single requester: alternate-cycle grants, sample from the same edge.
    req = 4'b0100;
    for (int e = 0; e < 6; e++) begin
      @(negedge clk);
      chk("single_gnt", 32'(gnt), (e % 2 == 0) ? 32'd4 : 32'd0);
      if (e % 2 == 0) chk("single_rand", 32'(rand_out), 32'(m_edge_rand));
    end

    // Move the pointer to 2 by granting index 1, then wrap to 0 before 1.
    req = 4'b0010;
    @(negedge clk); chk("ptr_setup", 32'(gnt), 32'd2);
    req = 4'b0011;
    @(negedge clk); chk("wrap_first",  32'(gnt), 32'd1);
    @(negedge clk); chk("wrap_second", 32'(gnt), 32'd2);

    // Enable dropped: no grants, sample held; resume at saved pointer (2).
    held = m_edge_rand;
    req  = 4'b1111;
    en   = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("en_off_gnt",  32'(gnt),      32'd0);
      chk("en_off_hold", 32'(rand_out), 32'(held));
    end
    en = 1'b1;
    @(negedge clk); chk("en_resume", 32'(gnt), 32'd4);

    // Asynchronous reset while a grant is active, then a full warm-up.
    #2 rst_n = 1'b0;
    #1;
    chk("async_gnt",   32'(gnt),   32'd0);
    chk("async_ready", 32'(ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= WU; e++) begin
      @(negedge clk);
      chk("rewarm_gnt", 32'(gnt), 32'd0);
    end
    @(negedge clk); chk("rewarm_first", 32'(gnt), 32'd1);

    // Random traffic, checked by the model process.
    repeat (20000) begin
      @(negedge clk);
      req = N'($urandom_range(0, 15));
      en  = ($urandom_range(0, 7) != 0);
    end

    // Saturated load: fairness and sample average.
    req = 4'b1111;
    en  = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) cnt[i] = 0;
    sum = 0; total = 0;
    repeat (40960) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (gnt[i]) cnt[i]++;
      if (gnt != '0) begin
        sum += longint'(rand_out);
        total++;
      end
    end
    maxc = cnt[0]; minc = cnt[0];
    for (int i = 1; i < N; i++) begin
      if (cnt[i] > maxc) maxc = cnt[i];
      if (cnt[i] < minc) minc = cnt[i];
    end
    chk("sat_every_cycle", 32'(total), 32'd40960);
    chk("sat_fairness", 32'((maxc - minc) * 100 <= maxc), 32'd1);
    chk("sat_avg", 32'((sum * 2 - 64'd4095 * total) <= 40 * total &&
                       (64'd4095 * total - sum * 2) <= 40 * total), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
